// File: rtl/victim_wb_buffer.sv
// Write-back victim buffer: queues dirty lines evicted by the D-cache, drains them
// to unified memory one at a time (yielding to refills), and forwards buffered data
// to a pending refill on a line-address match.
module victim_wb_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             evict_valid,
  input  logic [13:0]      evict_addr,
  input  logic [63:0]      evict_data,
  output logic             evict_ready,
  input  logic             fill_req,
  input  logic [13:0]      lookup_addr,
  output logic             lookup_hit,
  output logic [63:0]      lookup_data,
  output logic             mem_we,
  output logic [13:0]      mem_addr,
  output logic [63:0]      mem_wdata,
  input  logic             mem_rdy,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] CountFull = (PTR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e             state_q, state_d;
  logic [DEPTH-1:0]   valid_q;
  logic [13:0]        addr_q [DEPTH];
  logic [63:0]        data_q [DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [PTR_W:0]     count_q;
  logic               push, pop;
  logic [PTR_W-1:0]   lookup_idx;

  assign evict_ready = (count_q != CountFull);
  assign push        = evict_valid && evict_ready;
  assign pop         = (state_q == StWrite) && mem_rdy;
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign mem_we      = (state_q == StWrite);

  // Head entry is gated by its valid bit so the memory side reads 0 when empty.
  assign mem_addr  = valid_q[head_q] ? addr_q[head_q] : '0;
  assign mem_wdata = valid_q[head_q] ? data_q[head_q] : '0;

  // Drain FSM next state: a write only starts when no refill is waiting.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if ((count_q != '0) && !fill_req) state_d = StWrite;
      StWrite: if (mem_rdy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state register; reset forces IDLE so mem_we drops asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Entry storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // Push and pop never target the same slot: push needs not-full, pop needs not-empty.
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= evict_addr;
        data_q[tail_q]  <= evict_data;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (push && !pop)      count_q <= count_q + (PTR_W + 1)'(1);
      else if (!push && pop) count_q <= count_q - (PTR_W + 1)'(1);
    end
  end

  // Lookup scans oldest to newest so the newest matching entry wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lookup_idx  = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lookup_idx = head_q + PTR_W'(i);
      if (valid_q[lookup_idx] && (addr_q[lookup_idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[lookup_idx];
      end
    end
  end

endmodule

// File: tb/tb_victim_wb_buffer.sv
// Directed bench for victim_wb_buffer with a scoreboard of expected memory writes.
module tb_victim_wb_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        evict_valid;
  logic [13:0] evict_addr;
  logic [63:0] evict_data;
  logic        evict_ready;
  logic        fill_req;
  logic [13:0] lookup_addr;
  logic        lookup_hit;
  logic [63:0] lookup_data;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_rdy;
  logic        empty;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [13:0] addr;
    logic [63:0] data;
  } line_t;

  line_t sb[$];

  victim_wb_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .evict_valid (evict_valid),
    .evict_addr  (evict_addr),
    .evict_data  (evict_data),
    .evict_ready (evict_ready),
    .fill_req    (fill_req),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdy     (mem_rdy),
    .empty       (empty),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a victim for one cycle; the scoreboard records it only if accepted.
  task automatic evict(input logic [13:0] a, input logic [63:0] d);
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = d;
    #1;
    if (evict_ready) sb.push_back('{addr: a, data: d});
    tick();
    evict_valid = 1'b0;
  endtask

  // Wait (bounded) for a write, check it against the scoreboard, hold it for
  // `hold` cycles checking stability, then complete it with a mem_rdy pulse.
  task automatic serve_write(input int hold);
    line_t exp;
    int n = 0;
    while (!mem_we && n < 20) begin
      tick();
      n++;
    end
    chk("mem_we_rise", mem_we, 1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    exp = sb.pop_front();
    chk("mem_addr", mem_addr, exp.addr);
    chk("mem_wdata", mem_wdata, exp.data);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_we", mem_we, 1);
      chk("hold_addr", mem_addr, exp.addr);
      chk("hold_wdata", mem_wdata, exp.data);
    end
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    chk("idle_gap_we", mem_we, 0);
  endtask

  initial begin
    line_t head;
    rst_n       = 1'b0;
    evict_valid = 1'b0;
    evict_addr  = '0;
    evict_data  = '0;
    fill_req    = 1'b0;
    lookup_addr = '0;
    mem_rdy     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_ready", evict_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_hit", lookup_hit, 0);
    chk("rst_ldata", lookup_data, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mdata", mem_wdata, 0);

    // Single line: mem_we rises the cycle after the push
    evict(14'h0123, 64'hDEAD_BEEF_0000_0001);
    chk("single_we_lat0", mem_we, 0);
    chk("single_count", count, 1);
    tick();
    chk("single_we_lat1", mem_we, 1);
    serve_write(3);
    chk("single_empty", empty, 1);
    chk("single_maddr0", mem_addr, 0);

    // Fill blocks drains; buffer fills, fifth push ignored
    fill_req = 1'b1;
    for (int i = 0; i < 4; i++)
      evict(14'h0200 + 14'(i), 64'h1111_0000_0000_0000 + 64'(i));
    chk("full_count", count, 4);
    chk("full_ready", evict_ready, 0);
    evict(14'h03FF, 64'hBAD0_BAD0_BAD0_BAD0);
    chk("full_ignored", count, 4);
    tick();
    chk("fill_blocks_we", mem_we, 0);
    fill_req = 1'b0;
    for (int i = 0; i < 4; i++) serve_write(i);
    chk("drain_empty", empty, 1);

    // Duplicate line: newest data forwarded; same-cycle push not yet visible
    fill_req    = 1'b1;
    lookup_addr = 14'h0040;
    evict_valid = 1'b1;
    evict_addr  = 14'h0040;
    evict_data  = 64'hAAAA_AAAA_AAAA_AAAA;
    #1;
    chk("push_invisible", lookup_hit, 0);
    evict_valid = 1'b0;
    evict(14'h0040, 64'hAAAA_AAAA_AAAA_AAAA);
    evict(14'h0040, 64'hBBBB_BBBB_BBBB_BBBB);
    chk("dup_hit", lookup_hit, 1);
    chk("dup_data", lookup_data, 64'hBBBB_BBBB_BBBB_BBBB);
    fill_req = 1'b0;
    serve_write(1);
    chk("dup_hit_after_pop", lookup_hit, 1);
    chk("dup_data_after_pop", lookup_data, 64'hBBBB_BBBB_BBBB_BBBB);
    serve_write(0);
    chk("dup_miss", lookup_hit, 0);
    chk("dup_miss_data", lookup_data, 0);

    // Full buffer: push rejected in the pop cycle, accepted on the next
    fill_req = 1'b1;
    for (int i = 0; i < 4; i++)
      evict(14'h0300 + 14'(i), 64'h3333_0000_0000_0000 + 64'(i));
    fill_req = 1'b0;
    begin
      int n = 0;
      while (!mem_we && n < 20) begin
        tick();
        n++;
      end
    end
    chk("pp_we", mem_we, 1);
    head = sb.pop_front();
    chk("pp_maddr", mem_addr, head.addr);
    evict_valid = 1'b1;
    evict_addr  = 14'h0355;
    evict_data  = 64'h5555_5555_5555_5555;
    mem_rdy     = 1'b1;
    tick();
    mem_rdy = 1'b0;
    chk("pp_count_pop", count, 3);
    chk("pp_ready", evict_ready, 1);
    sb.push_back('{addr: 14'h0355, data: 64'h5555_5555_5555_5555});
    tick();
    evict_valid = 1'b0;
    chk("pp_count_push", count, 4);
    for (int i = 0; i < 4; i++) serve_write(1);
    chk("pp_empty", empty, 1);

    // Reset mid-write discards everything
    fill_req = 1'b1;
    evict(14'h0404, 64'h4444_0000_0000_0001);
    evict(14'h0405, 64'h4444_0000_0000_0002);
    fill_req    = 1'b0;
    lookup_addr = 14'h0405;
    tick();
    chk("mid_we", mem_we, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_count", count, 0);
    chk("arst_hit", lookup_hit, 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_we", mem_we, 0);
    end
    chk("post_rst_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
